dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-cycle CPU's word-wide data memory. Port 0 is the CPU load/store path; port 1 is the loader/debug path. The block grants one request at a time and performs loads, aligned word stores and byte/halfword stores. Sub-word stores use read-merge-write, so the memory only ever sees full, word-aligned writes.

Parameters:
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, data word width (fixed 32; byte lanes assume 4 bytes)
MEM_SIZE, 64, memory depth in words; addresses wrap modulo MEM_SIZE inside the memory, no range check here

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid_0/1  in  1  request valid, per port
req_ready_0/1  out  1  request accepted this cycle, per port
req_we_0/1  in  1  1=store, 0=load
req_size_0/1  in  2  00 byte, 01 half, 10 word, 11 illegal
req_addr_0/1  in  ADDR_WIDTH  byte address
req_wdata_0/1  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid_0/1  out  1  one-cycle completion pulse, per port
rsp_err_0/1  out  1  qualifies rsp_valid: misaligned or illegal size
rsp_rdata  out  DATA_WIDTH  raw aligned word read for last load, shared, valid with rsp_valid_x
mem_addr  out  ADDR_WIDTH  word-aligned address to memory ([1:0] always 00)
mem_wr_en  out  1  memory write strobe
mem_wr_data  out  DATA_WIDTH  full word written
mem_rd_data  in  DATA_WIDTH  combinational memory read of mem_addr

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all req_ready, rsp_valid, rsp_err, mem_wr_en = 0; mem_addr, mem_wr_data, rsp_rdata = 0; last_grant=1, so port 0 wins first.
- FSM states: IDLE -> ACCESS -> (WRITE) -> DONE -> IDLE.
- IDLE:
  - Round-robin grant among valid ports. The port not in last_grant wins a tie.
  - req_ready_x=1 combinationally for the winner only.
  - Handshake occurs when valid&&ready. Capture port id, we, size, addr, wdata; update last_grant; go to ACCESS.
  - No valid request: stay in IDLE.
- ACCESS: mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> rsp_err set, no write, go to DONE.
  - Load: rsp_rdata <= mem_rd_data; go to DONE.
  - Word store: mem_wr_en=1, mem_wr_data=wdata; go to DONE.
  - Byte/half store: merge_reg <= mem_rd_data with addressed lane(s) replaced by wdata (byte lane = addr[1:0]; half lane = addr[1]); go to WRITE.
- WRITE: mem_wr_en=1, mem_wr_data=merge_reg, same mem_addr; go to DONE.
- DONE: rsp_valid_x=1 for the owning port only, rsp_err_x as set; go to IDLE.
- mem_wr_en is 0 in every state other than ACCESS (word store) and WRITE.
- Latency from handshake edge: load / word store / error = 2 cycles to rsp_valid; sub-word store = 3 cycles. Next grant is possible in the cycle after DONE (IDLE).
- Holding: a requester keeps valid/addr/data stable until ready. Requests arriving while busy wait, with no ready.
- Simultaneous valid on both ports in IDLE: exactly one ready. The loser is granted next unless it drops valid.
- Reset mid-operation aborts immediately. A pending WRITE is not issued and no rsp_valid is produced.

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins simultaneous requests and last_grant is unused. Port 1 is granted only when req_valid_0=0 in IDLE. When undefined, round-robin as above.

Test Plan:
- Reset then port0 load addr 0x8, memory word 2 = 0xAABBCCDD -> req_ready_0 in cycle of valid, rsp_valid_0 pulse 2 cycles later, rsp_rdata=0xAABBCCDD, rsp_err_0=0, mem_wr_en never high.
- Word 1 preloaded 0x11223344; port1 byte store 0x5A to addr 0x6 -> one mem_wr_en pulse, mem_addr=0x4, mem_wr_data=0x115A3344; rsp_valid_1 3 cycles after handshake.
- Half store 0xBEEF to addr 0x2 over 0x00000000 -> writes 0xBEEF0000; half store to addr 0x3 -> rsp_err=1, no mem_wr_en, memory unchanged.
- Both ports valid continuously, each issuing word loads -> grants alternate 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN defined -> port 1 never granted while port 0 is valid.
- Assert rst_n=0 in the WRITE-pending cycle of a byte store (during ACCESS) -> no mem_wr_en, no rsp_valid, all outputs 0, next request granted to port 0.
- size=11 word-aligned store of 0xFFFFFFFF -> rsp_err pulse, memory unchanged.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its environment.
// slave  : the arbiter's view (it takes the two request ports and drives the memory).
// master : the environment's view (the CPU/loader requesters and the memory itself).
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Port 0: CPU load/store path
  logic                  req_valid_0;
  logic                  req_ready_0;
  logic                  req_we_0;
  logic [1:0]            req_size_0;
  logic [ADDR_WIDTH-1:0] req_addr_0;
  logic [DATA_WIDTH-1:0] req_wdata_0;
  logic                  rsp_valid_0;
  logic                  rsp_err_0;

  // Port 1: loader/debug path
  logic                  req_valid_1;
  logic                  req_ready_1;
  logic                  req_we_1;
  logic [1:0]            req_size_1;
  logic [ADDR_WIDTH-1:0] req_addr_1;
  logic [DATA_WIDTH-1:0] req_wdata_1;
  logic                  rsp_valid_1;
  logic                  rsp_err_1;

  // Shared load data
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Word-wide memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  req_valid_0, req_we_0, req_size_0, req_addr_0, req_wdata_0,
    output req_ready_0, rsp_valid_0, rsp_err_0,
    input  req_valid_1, req_we_1, req_size_1, req_addr_1, req_wdata_1,
    output req_ready_1, rsp_valid_1, rsp_err_1,
    output rsp_rdata,
    output mem_addr, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output req_valid_0, req_we_0, req_size_0, req_addr_0, req_wdata_0,
    input  req_ready_0, rsp_valid_0, rsp_err_0,
    output req_valid_1, req_we_1, req_size_1, req_addr_1, req_wdata_1,
    input  req_ready_1, rsp_valid_1, rsp_err_1,
    input  rsp_rdata,
    input  mem_addr, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a word-wide data memory.
// Grants one request at a time; loads and aligned word stores take one memory
// cycle, byte/halfword stores are done as read-merge-write so the memory only
// ever sees full word-aligned writes.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie
// (default build: round-robin between the two ports).
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte lanes are hard-wired to a 4-byte word; address wrap lives in the memory.
  if (DATA_WIDTH != 32 || MEM_SIZE < 1) begin : g_bad_cfg
    $error("dmem_arbiter: DATA_WIDTH must be 32 and MEM_SIZE positive");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  // Captured request
  logic                  port_reg;
  logic                  we_reg;
  logic [1:0]            size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  // Result state
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] merge_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Port granted most recently; the other port wins the next tie.
  logic                  last_grant_reg;
`endif

  logic                  grant_valid;
  logic                  grant_port;
  logic                  handshake;
  logic                  access_err;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [NUM_LANES-1:0]  lane_en;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] merged;

  // Pick the winner among valid requesters.
  always_comb begin
    grant_valid = bus.req_valid_0 | bus.req_valid_1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant_port  = ~bus.req_valid_0;
`else
    if (bus.req_valid_0 && bus.req_valid_1) begin
      grant_port = ~last_grant_reg;
    end else begin
      grant_port = ~bus.req_valid_0;
    end
`endif
  end

  // Ready is only offered in IDLE, to the winner, and never while reset is held.
  assign bus.req_ready_0 = rst_n && (state_reg == IDLE) && grant_valid && !grant_port;
  assign bus.req_ready_1 = rst_n && (state_reg == IDLE) && grant_valid &&  grant_port;
  assign handshake       = (state_reg == IDLE) && grant_valid;

  assign word_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};

  // Illegal size or misalignment for the requested size.
  assign access_err = (size_reg == SZ_ILL) ||
                      ((size_reg == SZ_HALF) && addr_reg[0]) ||
                      ((size_reg == SZ_WORD) && (addr_reg[1:0] != 2'b00));

  // Per-lane merge of right-justified store data into the word just read.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE     = 2'(gi);
    localparam int         HALF_OFS = 8 * (gi % 2);

    assign lane_en[gi] = (size_reg == SZ_BYTE) ? (addr_reg[1:0] == LANE) :
                         (size_reg == SZ_HALF) ? (addr_reg[1] == LANE[1]) :
                                                 1'b1;

    assign lane_data[8*gi +: 8] = (size_reg == SZ_BYTE) ? wdata_reg[7:0] :
                                  (size_reg == SZ_HALF) ? wdata_reg[HALF_OFS +: 8] :
                                                          wdata_reg[8*gi +: 8];

    assign merged[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8]
                                           : bus.mem_rd_data[8*gi +: 8];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and memory/response outputs.
  always_comb begin
    state_next      = state_reg;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    bus.rsp_valid_0 = 1'b0;
    bus.rsp_valid_1 = 1'b0;
    bus.rsp_err_0   = 1'b0;
    bus.rsp_err_1   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (handshake) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_addr = word_addr;
        if (access_err || !we_reg) begin
          state_next = DONE;
        end else if (size_reg == SZ_WORD) begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_data = wdata_reg;
          state_next      = DONE;
        end else begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        bus.mem_addr    = word_addr;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = merge_reg;
        state_next      = DONE;
      end
      DONE: begin
        bus.rsp_valid_0 = !port_reg;
        bus.rsp_valid_1 =  port_reg;
        bus.rsp_err_0   = !port_reg && err_reg;
        bus.rsp_err_1   =  port_reg && err_reg;
        state_next      = IDLE;
      end
    endcase
  end

  // Request capture at the handshake and result capture during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_reg       <= 1'b0;
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      merge_reg      <= '0;
      rdata_reg      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      if (handshake) begin
        port_reg  <= grant_port;
        we_reg    <= grant_port ? bus.req_we_1    : bus.req_we_0;
        size_reg  <= grant_port ? bus.req_size_1  : bus.req_size_0;
        addr_reg  <= grant_port ? bus.req_addr_1  : bus.req_addr_0;
        wdata_reg <= grant_port ? bus.req_wdata_1 : bus.req_wdata_0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant_reg <= grant_port;
`endif
      end
      if (state_reg == ACCESS) begin
        err_reg <= access_err;
        if (!access_err && !we_reg) begin
          rdata_reg <= bus.mem_rd_data;
        end
        if (!access_err && we_reg && (size_reg != SZ_WORD)) begin
          merge_reg <= merged;
        end
      end
    end
  end

  assign bus.rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions plus
// hand-written sequences for arbitration and reset abort.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: combinational read, write on the clock edge, bench preload port.
  logic [31:0] mem [MS];
  logic        pre_en  = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
    else if (pre_en)   mem[pre_idx] <= pre_val;
  end
  assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    pre_idx = addr[7:2];
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic set_req(input logic p, input logic v, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (!p) begin
      bus.req_valid_0 = v; bus.req_we_0 = we; bus.req_size_0 = size;
      bus.req_addr_0 = addr; bus.req_wdata_0 = wdata;
    end else begin
      bus.req_valid_1 = v; bus.req_we_1 = we; bus.req_size_1 = size;
      bus.req_addr_1 = addr; bus.req_wdata_1 = wdata;
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input int i);
    vec_t v;
    int lat, wr, other;
    logic err;
    logic [31:0] rdata, wr_addr;
    v = vecs[i];
    preload(v.addr, v.pre);
    set_req(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
    @(negedge clk);
    check("ready_winner", v.port ? bus.req_ready_1 : bus.req_ready_0, 1);
    check("ready_other",  v.port ? bus.req_ready_0 : bus.req_ready_1, 0);
    @(posedge clk);
    #1 set_req(v.port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    lat = 0; wr = 0; other = 0; err = 1'b0; rdata = '0; wr_addr = '0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        wr++;
        wr_addr = bus.mem_addr;
      end
      if (v.port ? bus.rsp_valid_1 : bus.rsp_valid_0) begin
        lat   = k;
        err   = v.port ? bus.rsp_err_1 : bus.rsp_err_0;
        rdata = bus.rsp_rdata;
      end
      if (v.port ? bus.rsp_valid_0 : bus.rsp_valid_1) other++;
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL vec%0d_timeout: got no rsp_valid expected one within 8 cycles", i);
    end
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
    check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, v.exp_err});
    check($sformatf("vec%0d_wr_pulses", i), 32'(wr), 32'(v.exp_wr));
    check($sformatf("vec%0d_other_rsp", i), 32'(other), 32'd0);
    check($sformatf("vec%0d_mem_word", i), mem[v.addr[7:2]], v.exp_mem);
    if (v.exp_wr != 0) check($sformatf("vec%0d_wr_addr", i), wr_addr, v.addr & 32'hFFFF_FFFC);
    if (!v.we && !v.exp_err) check($sformatf("vec%0d_rdata", i), rdata, v.exp_rdata);
    $display("vec %0d: port %0d we %0d size %0d addr 0x%08h -> lat %0d err %0d wr %0d mem 0x%08h",
             i, v.port, v.we, v.size, v.addr, lat, err, wr, mem[v.addr[7:2]]);
  endtask

  int grants[4];
  int exp_grants[4];
  int n_grant;
  int both_ready;
  int bad_window;

  initial begin
    //            port we  size   addr          wdata          pre            err rdata          mem            lat wr
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0008, 32'h0,         32'hAABB_CCDD, 1'b0, 32'hAABB_CCDD, 32'hAABB_CCDD, 2, 0};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0006, 32'h0000_005A, 32'h1122_3344, 1'b0, 32'h0,         32'h115A_3344, 3, 1};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0002, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 32'h0,         32'hBEEF_0000, 3, 1};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0003, 32'h0000_BEEF, 32'h1234_5678, 1'b1, 32'h0,         32'h1234_5678, 2, 0};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, 32'h0000_0010, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1, 32'h0,         32'hCAFE_F00D, 2, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 2, 1};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h0000_001A, 32'h0,         32'h5566_7788, 1'b1, 32'h0,         32'h5566_7788, 2, 0};
    vecs[7]  = '{1'b1, 1'b1, 2'b00, 32'h0000_001F, 32'h0000_00A5, 32'h0011_2233, 1'b0, 32'h0,         32'hA511_2233, 3, 1};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'hFFFF_FF7E, 32'h1111_1111, 1'b0, 32'h0,         32'h1111_117E, 3, 1};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0026, 32'hFFFF_5566, 32'hAAAA_AAAA, 1'b0, 32'h0,         32'h5566_AAAA, 3, 1};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h0000_0029, 32'h0,         32'h0102_0304, 1'b0, 32'h0102_0304, 32'h0102_0304, 2, 0};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 32'h0000_0104, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 32'h0,         32'h0BAD_F00D, 2, 1};

`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_grants = '{0, 0, 0, 0};
`else
    exp_grants = '{0, 1, 0, 1};
`endif

    // Both ports request word loads while reset is held.
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b10, 32'h34, 32'h0);
    @(negedge clk);
    check("rst_ready_0", {31'b0, bus.req_ready_0}, 0);
    check("rst_ready_1", {31'b0, bus.req_ready_1}, 0);
    check("rst_rsp_valid", {30'b0, bus.rsp_valid_1, bus.rsp_valid_0}, 0);
    check("rst_rsp_err", {30'b0, bus.rsp_err_1, bus.rsp_err_0}, 0);
    check("rst_mem_wr_en", {31'b0, bus.mem_wr_en}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wr_data", bus.mem_wr_data, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports continuously valid: record the order of grants.
    n_grant = 0; both_ready = 0;
    for (int c = 0; c < 40 && n_grant < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready_0 && bus.req_ready_1) both_ready++;
      if (bus.req_ready_0) begin grants[n_grant] = 0; n_grant++; end
      else if (bus.req_ready_1) begin grants[n_grant] = 1; n_grant++; end
    end
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("grant_count", 32'(n_grant), 4);
    check("both_ready", 32'(both_ready), 0);
    for (int g = 0; g < 4; g++) begin
      if (g < n_grant) check($sformatf("grant_%0d", g), 32'(grants[g]), 32'(exp_grants[g]));
    end
    $display("arbitration: grants %0d %0d %0d %0d", grants[0], grants[1], grants[2], grants[3]);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset during ACCESS of a port-0 byte store: the write must never happen.
    preload(32'h4, 32'h1122_3344);
    set_req(1'b0, 1'b1, 1'b1, 2'b00, 32'h6, 32'h5A);
    @(negedge clk);
    check("abort_ready_0", {31'b0, bus.req_ready_0}, 1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_wr_en", {31'b0, bus.mem_wr_en}, 0);
    check("abort_rsp_valid", {30'b0, bus.rsp_valid_1, bus.rsp_valid_0}, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_ready", {30'b0, bus.req_ready_1, bus.req_ready_0}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b10, 32'h34, 32'h0);
    @(negedge clk);
    check("post_abort_ready_0", {31'b0, bus.req_ready_0}, 1);
    check("post_abort_ready_1", {31'b0, bus.req_ready_1}, 0);
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    bad_window = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) bad_window++;
    end
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    check("post_abort_wr_pulses", 32'(bad_window), 0);
    check("abort_mem_word", mem[1], 32'h1122_3344);
    $display("reset abort: mem[1] 0x%08h", mem[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
